// File: rtl/hu_fwd_scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hu_fwd_scoreboard                                                    |
// | E-stage operand forwarding with a long-latency write scoreboard.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module hu_fwd_scoreboard #(
  parameter int XLEN    = 32,
  parameter int NSRC    = 3,
  parameter int NPEND   = 4,
  parameter int TIMEOUT = 255,
  parameter int TAGW    = $clog2(NPEND)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4:0]           rs1_E,
  input  logic [4:0]           rs2_E,
  input  logic [4:0]           rd_E,
  input  logic                 ren_E,
  input  logic                 we_E,
  input  logic                 auipc_E,
  input  logic                 src_reg_E,
  input  logic [XLEN-1:0]      pc_E,
  input  logic [XLEN-1:0]      imm_E,
  input  logic [XLEN-1:0]      rdata1_E,
  input  logic [XLEN-1:0]      rdata2_E,
  input  logic [NSRC-1:0]      src_we,
  input  logic [NSRC-1:0]      src_rdy,
  input  logic [5*NSRC-1:0]    src_rd,
  input  logic [XLEN*NSRC-1:0] src_data,
  input  logic                 alloc_valid,
  input  logic [4:0]           alloc_rd,
  output logic                 alloc_ready,
  output logic [TAGW-1:0]      alloc_tag,
  input  logic                 ret_valid,
  input  logic [TAGW-1:0]      ret_tag,
  input  logic [XLEN-1:0]      ret_data,
  output logic [XLEN-1:0]      op_a,
  output logic [XLEN-1:0]      op_b,
  output logic [XLEN-1:0]      rs2_fwd,
  output logic                 stall_E,
  output logic [15:0]          stall_cnt,
  output logic                 hang_err,
  output logic                 ret_err
);

  localparam int RUNW = $clog2(TIMEOUT + 1);

  logic [NPEND-1:0] r_busy;
  logic [NPEND-1:0] r_newest;
  logic [4:0]       r_rd [NPEND];
  logic [15:0]      r_stall_cnt;
  logic [RUNW-1:0]  r_run;
  logic             r_hang;
  logic             r_ret_err;

  logic [NPEND-1:0] w_pend;
  logic             w_ret_hit;
  logic [4:0]       w_rs  [2];
  logic [XLEN-1:0]  w_rf  [2];
  logic [XLEN-1:0]  w_val [2];
  logic [1:0]       w_opstall;
  logic             w_waw;
  logic             w_free_any;
  logic [TAGW-1:0]  w_free_tag;

  assign w_ret_hit = ret_valid & r_busy[ret_tag];
  assign w_rs[0]   = rs1_E;
  assign w_rs[1]   = rs2_E;
  assign w_rf[0]   = rdata1_E;
  assign w_rf[1]   = rdata2_E;

  // Busy entries whose result is not arriving this cycle.
  generate
    for (genvar j = 0; j < NPEND; j++) begin : g_pend
      assign w_pend[j] = r_busy[j] & ~(ret_valid & (ret_tag == TAGW'(j)));
    end
  endgenerate

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      logic hit;
      hit          = 1'b0;
      w_val[k]     = '0;
      w_opstall[k] = 1'b0;
      if (ren_E && w_rs[k] != 5'd0) begin
        // An unready source blocks the operand; older sources are never consulted.
        for (int i = 0; i < NSRC; i++) begin
          if (!hit && src_we[i] && src_rd[i*5 +: 5] == w_rs[k]) begin
            hit = 1'b1;
            if (src_rdy[i]) w_val[k] = src_data[i*XLEN +: XLEN];
            else            w_opstall[k] = 1'b1;
          end
        end
        if (!hit) begin
          w_val[k] = w_rf[k];
          if (w_ret_hit && r_rd[ret_tag] == w_rs[k] && r_newest[ret_tag])
            w_val[k] = ret_data;
          for (int j = 0; j < NPEND; j++)
            if (w_pend[j] && r_rd[j] == w_rs[k]) w_opstall[k] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_waw = 1'b0;
    for (int j = 0; j < NPEND; j++)
      if (w_pend[j] && r_rd[j] == rd_E) w_waw = 1'b1;
    w_waw = w_waw & we_E & (rd_E != 5'd0);
  end

  always_comb begin
    w_free_any = 1'b0;
    w_free_tag = '0;
    for (int j = NPEND - 1; j >= 0; j--) begin
      if (!r_busy[j]) begin
        w_free_any = 1'b1;
        w_free_tag = TAGW'(j);
      end
    end
  end

  assign op_a        = auipc_E ? pc_E : w_val[0];
  assign op_b        = src_reg_E ? w_val[1] : imm_E;
  assign rs2_fwd     = w_val[1];
  assign stall_E     = w_opstall[0] | w_opstall[1] | w_waw;
  assign alloc_ready = w_free_any;
  assign alloc_tag   = w_free_tag;
  assign stall_cnt   = r_stall_cnt;
  assign hang_err    = r_hang;
  assign ret_err     = r_ret_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy      <= '0;
      r_newest    <= '0;
      for (int j = 0; j < NPEND; j++) r_rd[j] <= 5'd0;
      r_stall_cnt <= 16'd0;
      r_run       <= '0;
      r_hang      <= 1'b0;
      r_ret_err   <= 1'b0;
    end else begin
      if (ret_valid) begin
        if (r_busy[ret_tag]) begin
          r_busy[ret_tag]   <= 1'b0;
          r_newest[ret_tag] <= 1'b0;
        end else begin
          r_ret_err <= 1'b1;
        end
      end
      // The free tag was sampled before this edge's return, so they never collide.
      if (alloc_valid && w_free_any) begin
        for (int j = 0; j < NPEND; j++)
          if (r_busy[j] && r_rd[j] == alloc_rd) r_newest[j] <= 1'b0;
        r_busy[w_free_tag]   <= 1'b1;
        r_newest[w_free_tag] <= 1'b1;
        r_rd[w_free_tag]     <= alloc_rd;
      end
      if (stall_E) begin
        if (r_stall_cnt != 16'hFFFF) r_stall_cnt <= r_stall_cnt + 16'd1;
        if (r_run != RUNW'(TIMEOUT)) r_run <= r_run + 1'b1;
        if (r_run >= RUNW'(TIMEOUT - 1)) r_hang <= 1'b1;
      end else begin
        r_run <= '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hu_fwd_scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_hu_fwd_scoreboard                                                 |
// | Directed bench with a sequence-number scoreboard model.              |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_hu_fwd_scoreboard;
  localparam int XLEN  = 32;
  localparam int NSRC  = 3;
  localparam int NPEND = 4;
  localparam int TAGW  = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [4:0] rs1_E, rs2_E, rd_E, alloc_rd;
  logic ren_E, we_E, auipc_E, src_reg_E, alloc_valid, ret_valid;
  logic [XLEN-1:0] pc_E, imm_E, rdata1_E, rdata2_E, ret_data;
  logic [NSRC-1:0] src_we, src_rdy;
  logic [5*NSRC-1:0] src_rd;
  logic [XLEN*NSRC-1:0] src_data;
  logic [TAGW-1:0] ret_tag, alloc_tag;
  logic alloc_ready, stall_E, hang_err, ret_err;
  logic [XLEN-1:0] op_a, op_b, rs2_fwd;
  logic [15:0] stall_cnt;

  int n_chk = 0;
  int n_err = 0;

  hu_fwd_scoreboard dut (
    .clk(clk), .rst(rst), .rs1_E(rs1_E), .rs2_E(rs2_E), .rd_E(rd_E),
    .ren_E(ren_E), .we_E(we_E), .auipc_E(auipc_E), .src_reg_E(src_reg_E),
    .pc_E(pc_E), .imm_E(imm_E), .rdata1_E(rdata1_E), .rdata2_E(rdata2_E),
    .src_we(src_we), .src_rdy(src_rdy), .src_rd(src_rd), .src_data(src_data),
    .alloc_valid(alloc_valid), .alloc_rd(alloc_rd), .alloc_ready(alloc_ready),
    .alloc_tag(alloc_tag), .ret_valid(ret_valid), .ret_tag(ret_tag),
    .ret_data(ret_data), .op_a(op_a), .op_b(op_b), .rs2_fwd(rs2_fwd),
    .stall_E(stall_E), .stall_cnt(stall_cnt), .hang_err(hang_err), .ret_err(ret_err)
  );

  always #5 clk = ~clk;

  // Model: each allocation gets a sequence number; an entry is newest for
  // its rd iff its number is the last one ever handed out for that rd.
  bit   m_busy [NPEND];
  logic [4:0] m_rd [NPEND];
  int   m_seq  [NPEND];
  int   m_last [32] = '{default: -1};
  int   m_next = 0;
  int   m_scnt = 0;
  int   m_run  = 0;
  bit   m_hang = 0;
  bit   m_rerr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void m_fv(input logic [4:0] rs, input logic [31:0] rf,
                               output logic [31:0] v, output bit st);
    v = '0;
    st = 1'b0;
    if (!ren_E || rs == 5'd0) return;
    for (int i = 0; i < NSRC; i++) begin
      if (src_we[i] && src_rd[i*5 +: 5] == rs) begin
        if (src_rdy[i]) v = src_data[i*XLEN +: XLEN];
        else st = 1'b1;
        return;
      end
    end
    v = rf;
    for (int j = 0; j < NPEND; j++) begin
      if (m_busy[j] && m_rd[j] == rs) begin
        if (ret_valid && int'(ret_tag) == j) begin
          if (m_seq[j] == m_last[rs]) v = ret_data;
        end else begin
          st = 1'b1;
        end
      end
    end
  endfunction

  function automatic int m_free();
    for (int j = 0; j < NPEND; j++) if (!m_busy[j]) return j;
    return -1;
  endfunction

  function automatic void m_expect(output logic [31:0] ea, output logic [31:0] eb,
                                   output logic [31:0] er, output bit es);
    logic [31:0] v1, v2;
    bit s1, s2, waw;
    m_fv(rs1_E, rdata1_E, v1, s1);
    m_fv(rs2_E, rdata2_E, v2, s2);
    waw = 1'b0;
    if (we_E && rd_E != 5'd0)
      for (int j = 0; j < NPEND; j++)
        if (m_busy[j] && m_rd[j] == rd_E && !(ret_valid && int'(ret_tag) == j)) waw = 1'b1;
    ea = auipc_E ? pc_E : v1;
    eb = src_reg_E ? v2 : imm_E;
    er = v2;
    es = s1 | s2 | waw;
  endfunction

  always @(posedge clk or posedge rst) begin : model_update
    logic [31:0] a, b, r;
    bit es;
    int ft;
    if (rst) begin
      for (int j = 0; j < NPEND; j++) m_busy[j] = 1'b0;
      for (int q = 0; q < 32; q++) m_last[q] = -1;
      m_scnt = 0; m_run = 0; m_hang = 1'b0; m_rerr = 1'b0;
    end else begin
      m_expect(a, b, r, es);
      ft = m_free();
      if (es) begin
        if (m_scnt < 65535) m_scnt++;
        m_run++;
        if (m_run >= 255) m_hang = 1'b1;
      end else begin
        m_run = 0;
      end
      if (ret_valid) begin
        if (m_busy[ret_tag]) m_busy[ret_tag] = 1'b0;
        else m_rerr = 1'b1;
      end
      if (alloc_valid && ft >= 0) begin
        m_busy[ft] = 1'b1;
        m_rd[ft]   = alloc_rd;
        m_seq[ft]  = m_next;
        m_last[alloc_rd] = m_next;
        m_next++;
      end
    end
  end

  always @(negedge clk) begin : compare
    logic [31:0] ea, eb, er;
    bit es;
    int ft;
    m_expect(ea, eb, er, es);
    ft = m_free();
    chk("m_stall_E", {31'd0, stall_E}, {31'd0, es});
    if (!es) begin
      chk("m_op_a", op_a, ea);
      chk("m_op_b", op_b, eb);
      chk("m_rs2_fwd", rs2_fwd, er);
    end
    chk("m_alloc_ready", {31'd0, alloc_ready}, {31'd0, ft >= 0});
    if (ft >= 0) chk("m_alloc_tag", {30'd0, alloc_tag}, ft);
    chk("m_stall_cnt", {16'd0, stall_cnt}, m_scnt);
    chk("m_hang_err", {31'd0, hang_err}, {31'd0, m_hang});
    chk("m_ret_err", {31'd0, ret_err}, {31'd0, m_rerr});
  end

  task automatic clr();
    rs1_E = 0; rs2_E = 0; rd_E = 0; ren_E = 0; we_E = 0; auipc_E = 0; src_reg_E = 0;
    pc_E = 0; imm_E = 0; rdata1_E = 0; rdata2_E = 0;
    src_we = 0; src_rdy = 0; src_rd = 0; src_data = 0;
    alloc_valid = 0; alloc_rd = 0; ret_valid = 0; ret_tag = 0; ret_data = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clr();
    #1 rst = 1'b1;
    #10;
    chk("rst_alloc_ready", {31'd0, alloc_ready}, 32'd1);
    chk("rst_alloc_tag", {30'd0, alloc_tag}, 32'd0);
    chk("rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
    cyc();
    rst = 1'b0;

    // Source priority and enables
    cyc(); clr();
    ren_E = 1; rs1_E = 5; rs2_E = 5; src_reg_E = 1; rdata1_E = 32'hDEAD;
    src_we = 3'b011; src_rdy = 3'b011; src_rd = {5'd0, 5'd5, 5'd5};
    src_data = {32'h33, 32'h22, 32'h11};
    #2 chk("src0_op_a", op_a, 32'h11); chk("src0_stall", {31'd0, stall_E}, 32'd0);
    cyc(); src_we = 3'b010;
    #2 chk("src1_op_a", op_a, 32'h22);
    cyc(); src_we = 3'b011; src_rdy = 3'b010;
    #2 chk("src0_unready_stall", {31'd0, stall_E}, 32'd1);
    cyc(); src_rdy = 3'b011; ren_E = 0;
    #2 chk("ren0_op_a", op_a, 32'h0); chk("ren0_rs2", rs2_fwd, 32'h0);
    cyc(); ren_E = 1; auipc_E = 1; pc_E = 32'h1000; src_reg_E = 0; imm_E = 32'h7;
    #2 chk("auipc_op_a", op_a, 32'h1000); chk("imm_op_b", op_b, 32'h7);

    // Long-latency operand: stall, forward on return, then free
    cyc(); clr(); alloc_valid = 1; alloc_rd = 7; rdata2_E = 32'h55;
    #2 chk("alloc_tag0", {30'd0, alloc_tag}, 32'd0);
    cyc(); alloc_valid = 0; rs2_E = 7; src_reg_E = 1; ren_E = 1;
    #2 chk("ll_stall", {31'd0, stall_E}, 32'd1);
    cyc(); ret_valid = 1; ret_tag = 0; ret_data = 32'hABCD;
    #2 chk("ret_fwd_op_b", op_b, 32'hABCD); chk("ret_fwd_stall", {31'd0, stall_E}, 32'd0);
    cyc(); ret_valid = 0;
    #2 chk("after_ret_op_b", op_b, 32'h55); chk("after_ret_tag", {30'd0, alloc_tag}, 32'd0);

    // Full scoreboard; a same-cycle return does not open a slot yet
    cyc(); clr(); alloc_valid = 1;
    for (int k = 1; k <= 4; k++) begin alloc_rd = 5'(k); cyc(); end
    #2 chk("full_ready", {31'd0, alloc_ready}, 32'd0);
    alloc_rd = 10; ret_valid = 1; ret_tag = 2;
    cyc(); alloc_valid = 0; ret_valid = 0;
    #2 chk("reuse_ready", {31'd0, alloc_ready}, 32'd1); chk("reuse_tag", {30'd0, alloc_tag}, 32'd2);
    cyc(); ret_valid = 1; ret_tag = 0;
    cyc(); ret_tag = 1;
    cyc(); ret_tag = 3;
    cyc(); ret_valid = 0;

    // WAW stall, x0 operand
    cyc(); alloc_valid = 1; alloc_rd = 3;
    cyc(); alloc_valid = 0; we_E = 1; rd_E = 3; ren_E = 1; rs1_E = 0; rdata1_E = 32'hFF;
    #2 chk("waw_stall", {31'd0, stall_E}, 32'd1); chk("x0_op_a", op_a, 32'h0);
    cyc();
    #2 chk("waw_stall2", {31'd0, stall_E}, 32'd1);
    ret_valid = 1; ret_tag = 0;
    #1 chk("waw_ret_nostall", {31'd0, stall_E}, 32'd0);
    cyc(); ret_valid = 0;
    #2 chk("waw_done", {31'd0, stall_E}, 32'd0);

    // Only the newest entry for an rd forwards on return
    cyc(); clr(); alloc_valid = 1; alloc_rd = 9;
    cyc(); cyc(); alloc_valid = 0; ren_E = 1; rs1_E = 9; rdata1_E = 32'h99;
    ret_valid = 1; ret_tag = 0; ret_data = 32'h1234;
    #2 chk("old_ret_stall", {31'd0, stall_E}, 32'd1);
    cyc(); ret_tag = 1; ret_data = 32'h5678;
    #2 chk("new_ret_op_a", op_a, 32'h5678); chk("new_ret_stall", {31'd0, stall_E}, 32'd0);
    cyc(); ret_valid = 0;
    #2 chk("regfile_op_a", op_a, 32'h99);

    // Hang detection, return errors, reset
    cyc(); clr(); rst = 1;
    cyc(); rst = 0; alloc_valid = 1; alloc_rd = 3;
    cyc(); alloc_valid = 0; we_E = 1; rd_E = 3;
    repeat (254) cyc();
    #2 chk("hang_pre", {31'd0, hang_err}, 32'd0); chk("cnt_254", {16'd0, stall_cnt}, 32'd254);
    cyc();
    #2 chk("hang_set", {31'd0, hang_err}, 32'd1); chk("cnt_255", {16'd0, stall_cnt}, 32'd255);
    we_E = 0; ret_valid = 1; ret_tag = 2;
    cyc(); ret_valid = 0;
    #2 chk("ret_err_free", {31'd0, ret_err}, 32'd1);
    rst = 1;
    #1 chk("rst2_ready", {31'd0, alloc_ready}, 32'd1); chk("rst2_hang", {31'd0, hang_err}, 32'd0);
    chk("rst2_ret_err", {31'd0, ret_err}, 32'd0); chk("rst2_cnt", {16'd0, stall_cnt}, 32'd0);
    cyc(); rst = 0; ret_valid = 1; ret_tag = 0;
    cyc(); ret_valid = 0;
    #2 chk("ret_err_discarded", {31'd0, ret_err}, 32'd1);
    cyc(); rst = 1;
    #2 chk("rst3_ret_err", {31'd0, ret_err}, 32'd0); chk("rst3_tag", {30'd0, alloc_tag}, 32'd0);
    cyc(); rst = 0;
    cyc();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
`default_nettype wire
